// File: rtl/well_pixel_pipe.sv
// Tetris well renderer feeding vgac d_in: border plus board cells drawn from a
// frame-synchronous shadow copy of the board, two-cycle address-to-pixel latency.
module well_pixel_pipe #(
  parameter int          WELL_X0    = 15,
  parameter int          WELL_Y0    = 4,
  parameter int          COLS       = 10,
  parameter int          ROWS       = 20,
  parameter logic [11:0] BORDER_RGB = 12'h00F
) (
  input  logic                     vga_clk,
  input  logic                     clrn,
  input  logic [8:0]               row_addr,
  input  logic [9:0]               col_addr,
  input  logic                     rdn,
  input  logic [2*COLS*ROWS-1:0]   board_in,
  input  logic                     upd_req,
  output logic                     upd_ack,
  output logic [11:0]              pix_out,
  output logic                     pix_valid,
  output logic [7:0]               frame_cnt
);

  localparam int NCELL = COLS * ROWS;
  localparam int CW    = $clog2(NCELL);

  localparam logic [9:0] XL = 10'(WELL_X0);
  localparam logic [9:0] XR = 10'(WELL_X0 + COLS + 1);
  localparam logic [9:0] YT = 10'(WELL_Y0);
  localparam logic [9:0] YB = 10'(WELL_Y0 + ROWS + 1);

  typedef enum logic {UPD_IDLE, UPD_PEND} upd_state_t;

  upd_state_t upd_state;
  logic [1:0] shadow      [NCELL];
  logic [1:0] board_cells [NCELL];

  logic [4:0] s1_ty;
  logic [5:0] s1_tx;
  logic       s1_edge;
  logic       s1_vis;

  logic       frame_end;
  logic [9:0] tx10, ty10, r10, c10, cell10;
  logic       on_border, interior;
  logic [1:0] code;
  logic [11:0] pix_d;

  // Cell code MSB sits at the lower bit index of each pair.
  for (genvar g = 0; g < NCELL; g++) begin : g_cells
    assign board_cells[g] = {board_in[2*g], board_in[2*g+1]};
  end

  always_comb begin
    frame_end = !rdn && (row_addr == 9'd479) && (col_addr == 10'd639);
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      s1_ty   <= '0;
      s1_tx   <= '0;
      s1_edge <= 1'b0;
      s1_vis  <= 1'b0;
    end else begin
      s1_ty   <= row_addr[8:4];
      s1_tx   <= col_addr[9:4];
      s1_edge <= (row_addr[3:0] == 4'h0) || (row_addr[3:0] == 4'hF) ||
                 (col_addr[3:0] == 4'h0) || (col_addr[3:0] == 4'hF);
      s1_vis  <= ~rdn;
    end
  end

  always_comb begin
    tx10      = 10'(s1_tx);
    ty10      = 10'(s1_ty);
    on_border = ((tx10 == XL || tx10 == XR) && ty10 >= YT && ty10 <= YB) ||
                ((ty10 == YT || ty10 == YB) && tx10 >= XL && tx10 <= XR);
    interior  = (tx10 > XL) && (tx10 < XR) && (ty10 > YT) && (ty10 < YB);
    // Row 0 of the board is the bottom row, just above the lower border.
    r10       = YB - 10'd1 - ty10;
    c10       = tx10 - XL - 10'd1;
    cell10    = interior ? (r10 * 10'(COLS) + c10) : '0;
    code      = shadow[cell10[CW-1:0]];
    pix_d     = '0;
    if (s1_vis) begin
      if (on_border) begin
        pix_d = s1_edge ? 12'h000 : BORDER_RGB;
      end else if (interior && !s1_edge) begin
        case (code)
          2'b01:   pix_d = 12'h00F;
          2'b10:   pix_d = 12'h0F0;
          2'b11:   pix_d = 12'hF00;
          default: pix_d = 12'h000;
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_out   <= pix_d;
      pix_valid <= s1_vis;
    end
  end

  // A request seen only on the frame-end cycle becomes pending and waits a frame.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      upd_state <= UPD_IDLE;
      upd_ack   <= 1'b0;
      frame_cnt <= '0;
      shadow    <= '{default: '0};
    end else begin
      upd_ack <= 1'b0;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (upd_state == UPD_PEND) begin
          if (upd_req) begin
            shadow  <= board_cells;
            upd_ack <= 1'b1;
          end
          upd_state <= UPD_IDLE;
        end else if (upd_req && !upd_ack) begin
          upd_state <= UPD_PEND;
        end
      end else if (upd_state == UPD_IDLE && upd_req && !upd_ack) begin
        upd_state <= UPD_PEND;
      end
    end
  end

endmodule

// File: tb/tb_well_pixel_pipe.sv
// Scoreboard bench for well_pixel_pipe: directed pixel reads with hand-computed
// colours, board update handshake, reset and frame counter wrap.
module tb_well_pixel_pipe;

  logic         vga_clk = 1'b0;
  logic         clrn;
  logic [8:0]   row_addr;
  logic [9:0]   col_addr;
  logic         rdn;
  logic [399:0] board_in;
  logic         upd_req;
  logic         upd_ack;
  logic [11:0]  pix_out;
  logic         pix_valid;
  logic [7:0]   frame_cnt;

  well_pixel_pipe #(
    .WELL_X0(15), .WELL_Y0(4), .COLS(10), .ROWS(20), .BORDER_RGB(12'h00F)
  ) dut (
    .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr),
    .rdn(rdn), .board_in(board_in), .upd_req(upd_req), .upd_ack(upd_ack),
    .pix_out(pix_out), .pix_valid(pix_valid), .frame_cnt(frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       name;
    logic [11:0] pix;
    logic        vld;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic trk = 1'b0, t1 = 1'b0, t2 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Marks which cycles carry a tracked read; the pixel appears two edges later.
  always @(posedge vga_clk) begin
    t1 <= trk;
    t2 <= t1;
  end

  always @(negedge vga_clk) begin
    if (t2) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got pixel %0h want no output", pix_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_pix"}, 32'(pix_out), 32'(e.pix));
        chk({e.name, "_vld"}, 32'(pix_valid), 32'(e.vld));
      end
    end
  end

  task automatic pix(input string nm, input int r, input int c, input logic rd,
                     input logic [11:0] ep, input logic ev);
    row_addr = 9'(r);
    col_addr = 10'(c);
    rdn      = rd;
    trk      = 1'b1;
    sbq.push_back('{name: nm, pix: ep, vld: ev});
    @(posedge vga_clk); #1;
    trk = 1'b0; rdn = 1'b1; row_addr = '0; col_addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge vga_clk); #1;
    end
  endtask

  task automatic fend(input logic req);
    row_addr = 9'd479;
    col_addr = 10'd639;
    rdn      = 1'b0;
    upd_req  = req;
    @(posedge vga_clk); #1;
    rdn = 1'b1; row_addr = '0; col_addr = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clrn = 1'b0; rdn = 1'b1; row_addr = '0; col_addr = '0;
    upd_req = 1'b0; board_in = '0;
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_pix", 32'(pix_out), 0);
    chk("rst_vld", 32'(pix_valid), 0);
    chk("rst_ack", 32'(upd_ack), 0);
    chk("rst_fc", 32'(frame_cnt), 0);
    clrn = 1'b1;
    idle(1);

    pix("border", 70, 245, 1'b0, 12'h00F, 1'b1);
    pix("border_edge", 70, 240, 1'b0, 12'h000, 1'b1);
    idle(3);
    pix("pre_copy", 392, 264, 1'b0, 12'h000, 1'b1);

    board_in[1] = 1'b1;
    upd_req = 1'b1;
    idle(3);
    fend(1'b1);
    chk("ack1", 32'(upd_ack), 1);
    chk("fc1", 32'(frame_cnt), 1);
    upd_req = 1'b0;
    idle(1);
    chk("ack1_off", 32'(upd_ack), 0);
    pix("c00", 392, 264, 1'b0, 12'h00F, 1'b1);
    pix("c00_edge", 392, 256, 1'b0, 12'h000, 1'b1);

    board_in[398] = 1'b1; board_in[399] = 1'b1; board_in[106] = 1'b1;
    upd_req = 1'b1;
    idle(2);
    fend(1'b1);
    chk("ack2", 32'(upd_ack), 1);
    upd_req = 1'b0;
    idle(1);
    pix("c199", 88, 408, 1'b0, 12'hF00, 1'b1);
    pix("c53", 312, 312, 1'b0, 12'h0F0, 1'b1);
    pix("c00_keep", 392, 264, 1'b0, 12'h00F, 1'b1);

    board_in = '0;
    idle(2);
    pix("noreq_a", 392, 264, 1'b0, 12'h00F, 1'b1);
    fend(1'b0);
    chk("ack_noreq", 32'(upd_ack), 0);
    idle(2);
    pix("noreq_b", 88, 408, 1'b0, 12'hF00, 1'b1);

    upd_req = 1'b1;
    pix("row200", 200, 100, 1'b0, 12'h000, 1'b1);
    idle(3);
    pix("req_wait", 392, 264, 1'b0, 12'h00F, 1'b1);
    fend(1'b1);
    chk("ack3", 32'(upd_ack), 1);
    upd_req = 1'b0;
    idle(2);
    pix("cleared", 392, 264, 1'b0, 12'h000, 1'b1);
    pix("cleared2", 88, 408, 1'b0, 12'h000, 1'b1);

    board_in[1] = 1'b1;
    idle(1);
    fend(1'b1);
    chk("ack_simul", 32'(upd_ack), 0);
    idle(2);
    pix("simul_old", 392, 264, 1'b0, 12'h000, 1'b1);
    fend(1'b1);
    chk("ack_simul2", 32'(upd_ack), 1);
    upd_req = 1'b0;
    idle(2);
    pix("simul_new", 392, 264, 1'b0, 12'h00F, 1'b1);

    pix("rdn_hi", 392, 264, 1'b1, 12'h000, 1'b0);
    pix("outside", 0, 0, 1'b0, 12'h000, 1'b1);
    chk("fc6", 32'(frame_cnt), 6);
    idle(3);

    board_in[398] = 1'b1; board_in[399] = 1'b1;
    upd_req = 1'b1;
    idle(2);
    clrn = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(upd_ack), 0);
    chk("mid_rst_fc", 32'(frame_cnt), 0);
    chk("mid_rst_vld", 32'(pix_valid), 0);
    chk("mid_rst_pix", 32'(pix_out), 0);
    @(posedge vga_clk); #1;
    clrn = 1'b1;
    fend(1'b1);
    chk("ack_after_rst", 32'(upd_ack), 0);
    chk("fc_after_rst", 32'(frame_cnt), 1);
    upd_req = 1'b0;
    idle(2);
    pix("shadow_zero", 392, 264, 1'b0, 12'h000, 1'b1);
    pix("shadow_zero2", 88, 408, 1'b0, 12'h000, 1'b1);

    repeat (254) fend(1'b0);
    chk("fc255", 32'(frame_cnt), 255);
    fend(1'b0);
    chk("fc_wrap", 32'(frame_cnt), 0);

    idle(4);
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
